// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default frame parameters and frame length helper.
// Used by both the transmitter and (later) the receiver.
package uart_pkg;

  localparam int WIDTH_WORD_DEF    = 8;
  localparam int CANT_BIT_STOP_DEF = 2;
  localparam int TICKS_PER_BIT_DEF = 16;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } uart_state_e;

  function automatic int FRAME_TICKS(input int width_word, input int cant_bit_stop,
                                     input int ticks_per_bit);
    return (1 + width_word + cant_bit_stop) * ticks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side handshake of the UART transmitter plus its serial line and status outputs.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int WIDTH_WORD = WIDTH_WORD_DEF
);
  logic                  i_tx_start;
  logic [WIDTH_WORD-1:0] i_data_in;
  logic                  o_bit_tx;
  logic                  o_tx_done;
  logic                  o_busy;

  modport master (
    output i_tx_start, i_data_in,
    input  o_bit_tx, o_tx_done, o_busy
  );

  modport slave (
    input  i_tx_start, i_data_in,
    output o_bit_tx, o_tx_done, o_busy
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Modulo-TICKS_PER_BIT tick counter; o_tick_tc is high during the last tick of each bit period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
  input  logic i_rate,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick_tc
);
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BIT - 1);

  logic [TW-1:0] tick_cnt;

  always_ff @(posedge i_rate) begin
    if (i_reset || i_clear) begin
      tick_cnt <= '0;
    end else if (tick_cnt == LAST_TICK) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign o_tick_tc = (tick_cnt == LAST_TICK) && !i_clear;
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH_WORD data bits LSB-first, CANT_BIT_STOP stop bits.
// Every output is registered; the line value is computed one state ahead so it changes on the same edge as the state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH_WORD    = WIDTH_WORD_DEF,
  parameter int CANT_BIT_STOP = CANT_BIT_STOP_DEF,
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
  input  logic      i_rate,
  input  logic      i_reset,
  uart_tx_if.slave  tx_if
);
  localparam int IDX_W  = (WIDTH_WORD > 1) ? $clog2(WIDTH_WORD) : 1;
  localparam int STOP_W = (CANT_BIT_STOP > 1) ? $clog2(CANT_BIT_STOP) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIDTH_WORD - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(CANT_BIT_STOP - 1);

  uart_state_e           state_q, state_n;
  logic [WIDTH_WORD-1:0] shreg_q, shreg_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic [STOP_W-1:0]     stop_q, stop_n;
  logic                  bit_q, bit_n;
  logic                  done_q, done_n;
  logic                  busy_q, busy_n;
  logic                  timer_clr;
  logic                  tick_tc;

  uart_bit_timer #(
    .TICKS_PER_BIT (TICKS_PER_BIT)
  ) u_bit_timer (
    .i_rate    (i_rate),
    .i_reset   (i_reset),
    .i_clear   (timer_clr),
    .o_tick_tc (tick_tc)
  );

  always_comb begin
    state_n   = state_q;
    shreg_n   = shreg_q;
    idx_n     = idx_q;
    stop_n    = stop_q;
    bit_n     = bit_q;
    done_n    = 1'b0;
    busy_n    = busy_q;
    timer_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Timer held clear while idle so the start bit gets a full period from the accepting edge.
        timer_clr = 1'b1;
        bit_n     = 1'b1;
        busy_n    = 1'b0;
        if (tx_if.i_tx_start) begin
          shreg_n = tx_if.i_data_in;
          state_n = ST_START;
          bit_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      ST_START: begin
        if (tick_tc) begin
          state_n = ST_DATA;
          idx_n   = '0;
          bit_n   = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (tick_tc) begin
          if (idx_q == LAST_IDX) begin
            state_n = ST_STOP;
            stop_n  = '0;
            bit_n   = 1'b1;
          end else begin
            idx_n = idx_q + 1'b1;
            bit_n = shreg_q[idx_n];
          end
        end
      end
      ST_STOP: begin
        bit_n = 1'b1;
        if (tick_tc) begin
          if (stop_q == LAST_STOP) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            stop_n = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_n   = ST_IDLE;
        bit_n     = 1'b1;
        busy_n    = 1'b0;
        timer_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_rate) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      stop_q  <= '0;
      bit_q   <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      shreg_q <= shreg_n;
      idx_q   <= idx_n;
      stop_q  <= stop_n;
      bit_q   <= bit_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
    end
  end

  assign tx_if.o_bit_tx  = bit_q;
  assign tx_if.o_tx_done = done_q;
  assign tx_if.o_busy    = busy_q;
endmodule
